// File: rtl/adder_bist_ctrl.sv
// adder_bist_ctrl: LFSR-driven built-in self test for an external adder.
// Two 64-bit LFSRs generate operand pairs. The expected sum is delayed to
// match the adder latency (DUT_LAT) and compared against the returned sum.
// Optional feature macro: ADDER_BIST_FAIL_CAPTURE_EN adds first-fail capture
// ports (ff_valid, ff_a, ff_b, ff_sum, ff_index).
module adder_bist_ctrl #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned NUM_TESTS = 10000,
   parameter logic [63:0] SEED      = 64'd5,
   parameter int unsigned DUT_LAT   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] dut_sum,
   output logic             busy,
   output logic             done,
   output logic [31:0]      pass_cnt,
   output logic [31:0]      fail_cnt,
   output logic             all_pass
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
   ,
   output logic             ff_valid,
   output logic [WIDTH-1:0] ff_a,
   output logic [WIDTH-1:0] ff_b,
   output logic [WIDTH-1:0] ff_sum,
   output logic [31:0]      ff_index
`endif
);

   localparam logic [63:0] SEED_B = SEED ^ 64'hA5A5_A5A5_A5A5_A5A5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t      state, state_nx;
   logic [63:0] lfsr_a, lfsr_b, lfsr_a_nx, lfsr_b_nx;
   logic [31:0] issue_cnt;
   logic [2:0]  drain_cnt;
   logic        start_ok, last_issue, run;
   logic [WIDTH-1:0] exp_now, cmp_exp;
   logic        cmp_vld;

   assign lfsr_a_nx  = {lfsr_a[62:0], lfsr_a[63] ^ lfsr_a[62] ^ lfsr_a[60] ^ lfsr_a[59]};
   assign lfsr_b_nx  = {lfsr_b[62:0], lfsr_b[63] ^ lfsr_b[62] ^ lfsr_b[60] ^ lfsr_b[59]};
   assign start_ok   = start && (state == S_IDLE || state == S_DONE);
   assign last_issue = (issue_cnt == 32'(NUM_TESTS - 1));
   assign run        = (state == S_RUN);
   assign exp_now    = op_a + op_b;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
   logic [WIDTH-1:0] cmp_a, cmp_b;
`endif

   // Align expected sum (and operands when capturing) with the adder latency
   generate
      if (DUT_LAT == 0) begin : g_nolat
         assign cmp_vld = run;
         assign cmp_exp = exp_now;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
         assign cmp_a = op_a;
         assign cmp_b = op_b;
`endif
      end else begin : g_lat
         logic [DUT_LAT:1]            vld_pipe;
         logic [DUT_LAT:1][WIDTH-1:0] exp_pipe;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
         logic [DUT_LAT:1][WIDTH-1:0] a_pipe, b_pipe;
`endif
         // Shift register carrying compare-valid and expected sum
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_pipe <= '0;
               exp_pipe <= '0;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
               a_pipe   <= '0;
               b_pipe   <= '0;
`endif
            end else begin
               vld_pipe[1] <= run;
               exp_pipe[1] <= exp_now;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
               a_pipe[1]   <= op_a;
               b_pipe[1]   <= op_b;
`endif
               for (int i = 2; i <= DUT_LAT; i++) begin
                  vld_pipe[i] <= vld_pipe[i-1];
                  exp_pipe[i] <= exp_pipe[i-1];
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
                  a_pipe[i]   <= a_pipe[i-1];
                  b_pipe[i]   <= b_pipe[i-1];
`endif
               end
            end
         end
         assign cmp_vld = vld_pipe[DUT_LAT];
         assign cmp_exp = exp_pipe[DUT_LAT];
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
         assign cmp_a = a_pipe[DUT_LAT];
         assign cmp_b = b_pipe[DUT_LAT];
`endif
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (last_issue) state_nx = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
         S_DRAIN: if (drain_cnt == 3'(DUT_LAT - 1)) state_nx = S_DONE;
         S_DONE:  if (start) state_nx = S_RUN;
         default: state_nx = S_IDLE;
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      busy     = (state == S_RUN) || (state == S_DRAIN);
      done     = (state == S_DONE);
      all_pass = done && (fail_cnt == '0) && (pass_cnt == 32'(NUM_TESTS));
   end

   // Operand generation, issue/drain counting and result scoring
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_a    <= SEED;
         lfsr_b    <= SEED_B;
         op_a      <= '0;
         op_b      <= '0;
         issue_cnt <= '0;
         drain_cnt <= '0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
         ff_valid  <= 1'b0;
         ff_a      <= '0;
         ff_b      <= '0;
         ff_sum    <= '0;
         ff_index  <= '0;
`endif
      end else if (start_ok) begin
         lfsr_a    <= SEED;
         lfsr_b    <= SEED_B;
         op_a      <= SEED[WIDTH-1:0];
         op_b      <= SEED_B[WIDTH-1:0];
         issue_cnt <= '0;
         drain_cnt <= '0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
         ff_valid  <= 1'b0;
         ff_a      <= '0;
         ff_b      <= '0;
         ff_sum    <= '0;
         ff_index  <= '0;
`endif
      end else begin
         // operands freeze on the last vector so they hold outside RUN
         if (run && !last_issue) begin
            lfsr_a    <= lfsr_a_nx;
            lfsr_b    <= lfsr_b_nx;
            op_a      <= lfsr_a_nx[WIDTH-1:0];
            op_b      <= lfsr_b_nx[WIDTH-1:0];
            issue_cnt <= issue_cnt + 32'd1;
         end
         if (run)                  drain_cnt <= '0;
         else if (state == S_DRAIN) drain_cnt <= drain_cnt + 3'd1;
         if (cmp_vld) begin
            if (dut_sum == cmp_exp) begin
               if (pass_cnt != '1) pass_cnt <= pass_cnt + 32'd1;
            end else begin
               if (fail_cnt != '1) fail_cnt <= fail_cnt + 32'd1;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
               // compares retire in order, so the running total is the index
               if (!ff_valid) begin
                  ff_valid <= 1'b1;
                  ff_a     <= cmp_a;
                  ff_b     <= cmp_b;
                  ff_sum   <= dut_sum;
                  ff_index <= pass_cnt + fail_cnt;
               end
`endif
            end
         end
      end
   end

endmodule

// File: doc/adder_bist_ctrl.md
ADDER_BIST_CTRL -- requirements
Module: adder_bist_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/sum width (legal 1..64).
REQ-002 SHALL have parameter NUM_TESTS, default 10000, meaning vectors issued per run (legal 1..2^32-1).
REQ-003 SHALL have parameter SEED, default 5, meaning 64-bit nonzero LFSR seed.
REQ-004 SHALL have parameter DUT_LAT, default 0, meaning DUT operand-to-sum latency in cycles (legal 0..7).
REQ-005 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  begin a run; sampled in IDLE or DONE only.
REQ-008 SHALL have port op_a  output  WIDTH  operand A driven to the external adder under test.
REQ-009 SHALL have port op_b  output  WIDTH  operand B driven to the external adder under test.
REQ-010 SHALL have port dut_sum  input  WIDTH  sum returned by the adder under test.
REQ-011 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-012 SHALL have port done  output  1  high in DONE.
REQ-013 SHALL have port pass_cnt  output  32  matching comparisons this run.
REQ-014 SHALL have port fail_cnt  output  32  mismatching comparisons this run.
REQ-015 SHALL have port all_pass  output  1  done AND fail_cnt==0 AND pass_cnt==NUM_TESTS.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DRAIN, DONE; IDLE/DONE -> RUN on start=1; RUN -> DRAIN after issuing vector NUM_TESTS-1 (straight to DONE if DUT_LAT=0 and last compare done); DRAIN -> DONE after last comparison; DONE holds until start.
REQ-017 SHALL, on the start edge, clear pass_cnt/fail_cnt, load lfsr_a=SEED and lfsr_b=SEED^64'hA5A5_A5A5_A5A5_A5A5, clear issue counter.
REQ-018 SHALL use two 64-bit Fibonacci LFSRs, shift left, feedback bit0 = b63^b62^b60^b59, each advancing once per RUN cycle.
REQ-019 SHALL drive op_a=lfsr_a[WIDTH-1:0], op_b=lfsr_b[WIDTH-1:0]; vector k (k=0..NUM_TESTS-1) presented in the k-th cycle after the start edge; operands hold last value outside RUN.
REQ-020 SHALL compute expected=(op_a+op_b) mod 2^WIDTH (carry discarded) and delay it DUT_LAT cycles through a shift register.
REQ-021 SHALL compare dut_sum to delayed expected at the edge ending cycle k+DUT_LAT, incrementing exactly one of pass_cnt or fail_cnt per vector; no compares in IDLE/DONE or for pipeline slots beyond vector NUM_TESTS-1.
REQ-022 SHALL assert done from the edge N+DUT_LAT after the start edge (N=NUM_TESTS), with pass_cnt+fail_cnt==N.
REQ-023 SHALL ignore start while busy; start held high in DONE SHALL launch a new run each time DONE is reached.
REQ-024 SHALL saturate pass_cnt and fail_cnt at 32'hFFFF_FFFF.

Reset
REQ-025 SHALL, on rst_n=0 (any state, including mid-run), asynchronously force IDLE, busy=0, done=0, all_pass=0, pass_cnt=0, fail_cnt=0, op_a=0, op_b=0, LFSRs=SEED/SEED^A5..., delay line=0.
REQ-026 SHALL require a fresh start after reset deassertion; no run resumes.

Configuration
REQ-027 SHALL, with ADDER_BIST_FAIL_CAPTURE_EN defined, add outputs ff_valid(1), ff_a(WIDTH), ff_b(WIDTH), ff_sum(WIDTH), ff_index(32) capturing operands, dut_sum and vector index of the first mismatch per run; cleared on start and reset; later mismatches do not overwrite.
REQ-028 SHALL, without ADDER_BIST_FAIL_CAPTURE_EN, omit these ports and registers entirely; all other behaviour identical.

Verification
REQ-029 SHALL test WIDTH=8, NUM_TESTS=16, DUT_LAT=0, ideal adder -> done at edge 16 after start, pass_cnt=16, fail_cnt=0, all_pass=1.
REQ-030 SHALL test WIDTH=32, NUM_TESTS=100, DUT_LAT=3, 3-stage ideal pipelined adder -> done at edge 103, pass_cnt=100, all_pass=1.
REQ-031 SHALL test WIDTH=16 DUT with sum bit0 stuck at 0 -> fail_cnt equals count of vectors with odd expected sum (bench model), pass_cnt+fail_cnt=NUM_TESTS, all_pass=0; with macro, ff_index = first odd-sum vector index.
REQ-032 SHALL test rst_n pulsed low at vector 7 of 16 -> all outputs zero immediately, IDLE; new start gives identical op_a sequence as first run.
REQ-033 SHALL test start pulsed during RUN -> no restart, counts and done edge unchanged.
